// File: rtl/bus_pkg.sv
// Shared definitions for the slave-side request arbiters.
package bus_pkg;

  localparam int QTY_OF_DEVICES = 4;
  localparam int QTY_OF_MASTERS = 4;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Index of the highest set bit; callers pass a one-hot (or zero) vector.
  function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin winner selection: rotate the requests so ptr sits at bit 0,
// isolate the lowest set bit, then rotate the index back.
module rr_priority_picker #(
  parameter int N = bus_pkg::QTY_OF_MASTERS,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] win,
  output logic [W-1:0] idx
);
  import bus_pkg::*;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  int unsigned    sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    first = rot & (~rot + N'(1));
    sum   = 32'(ptr) + onehot_to_idx(32'(first));
    if (sum >= unsigned'(N)) sum = sum - unsigned'(N);
    win = '0;
    idx = '0;
    if (|req) begin
      win = N'(1) << sum;
      idx = W'(sum);
    end
  end

endmodule

// File: rtl/slave_request_arbiter.sv
// Per-slave round-robin arbiter with ack/withdraw/watchdog release.
// state    | meaning
// ARB_IDLE | no grant; pick the next winner from rr_ptr on any request
// ARB_BUSY | grant held for master_id until ack, withdraw or watchdog
module slave_request_arbiter #(
  parameter int QTY_OF_MASTERS = bus_pkg::QTY_OF_MASTERS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [QTY_OF_MASTERS-1:0]         request_from_masters,
  input  logic                              slave_ack,
  output logic [QTY_OF_MASTERS-1:0]         grant,
  output logic                              grant_valid,
  output logic [$clog2(QTY_OF_MASTERS)-1:0] master_id,
  output logic                              timeout_err
);
  import bus_pkg::*;

  localparam int IW = $clog2(QTY_OF_MASTERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t                state;
  logic [IW-1:0]             rr_ptr;
  logic [QTY_OF_MASTERS-1:0] pick_win;
  logic [IW-1:0]             pick_idx;
  logic                      timeout_hit;
  logic                      withdraw;
  logic                      release_now;

  rr_priority_picker #(.N(QTY_OF_MASTERS)) u_picker (
    .req (request_from_masters),
    .ptr (rr_ptr),
    .win (pick_win),
    .idx (pick_idx)
  );

  assign withdraw    = ~|(request_from_masters & grant);
  assign release_now = slave_ack | withdraw | timeout_hit;

  // Counter equals the number of completed BUSY cycles; fire as the last allowed one ends.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      logic [CW-1:0] wd_cnt;
      always_ff @(posedge clk) begin
        if (!rst_n)                                wd_cnt <= '0;
        else if (state == ARB_IDLE)                wd_cnt <= '0;
        else if (wd_cnt != CW'(TIMEOUT_CYCLES))    wd_cnt <= wd_cnt + CW'(1);
      end
      assign timeout_hit = (state == ARB_BUSY) && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      master_id   <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|request_from_masters) begin
            grant       <= pick_win;
            grant_valid <= 1'b1;
            master_id   <= pick_idx;
            state       <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            master_id   <= '0;
            state       <= ARB_IDLE;
            rr_ptr      <= (master_id == IW'(QTY_OF_MASTERS - 1)) ? '0 : master_id + IW'(1);
            // An ack or a withdraw on the same cycle makes this an orderly release.
            timeout_err <= timeout_hit & ~slave_ack & ~withdraw;
          end
        end
      endcase
    end
  end

  a_onehot: assert property (@(posedge clk) $onehot0(grant));
  a_valid:  assert property (@(posedge clk) grant_valid == (|grant));
  a_busy:   assert property (@(posedge clk) (grant != '0) == (state == ARB_BUSY));

endmodule

// File: tb/tb_slave_request_arbiter.sv
// Directed vectors plus timeout/reset sequences for slave_request_arbiter.
module tb_slave_request_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] master_id;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  slave_request_arbiter #(.QTY_OF_MASTERS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .request_from_masters (req),
    .slave_ack            (ack),
    .grant                (grant),
    .grant_valid          (grant_valid),
    .master_id            (master_id),
    .timeout_err          (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] q, input logic a,
                     input logic [3:0] g, input logic [1:0] id, input logic to);
    vec_t v;
    v.rst_n = r; v.req = q; v.ack = a; v.g = g; v.id = id; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] id, input logic to);
    total++;
    if (grant !== g || master_id !== id || timeout_err !== to || grant_valid !== (|g)) begin
      bad++;
      $display("FAIL %s: got grant=%b id=%0d to=%b gv=%b, want grant=%b id=%0d to=%b gv=%b",
               name, grant, master_id, timeout_err, grant_valid, g, id, to, |g);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b1111; ack = 1'b0;

    // reset held with all masters requesting
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    // single request from master 2, ack after four grant cycles
    add(1, 4'b0100, 0, 4'b0100, 2, 0);
    add(1, 4'b0100, 0, 4'b0100, 2, 0);
    add(1, 4'b0100, 0, 4'b0100, 2, 0);
    add(1, 4'b0100, 0, 4'b0100, 2, 0);
    add(1, 4'b0100, 1, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0);
    // search now starts at master 3
    add(1, 4'b1111, 0, 4'b1000, 3, 0);
    add(1, 4'b1111, 0, 4'b1000, 3, 0);
    add(1, 4'b1111, 1, 4'b0000, 0, 0);
    // round robin with all requesting
    for (int m = 0; m < 5; m++) begin
      add(1, 4'b1111, 0, 4'(1 << (m % 4)), 2'(m % 4), 0);
      add(1, 4'b1111, 0, 4'(1 << (m % 4)), 2'(m % 4), 0);
      add(1, 4'b1111, 1, 4'b0000, 0, 0);
    end
    // move rr_ptr to 3, then wrap and skip
    add(1, 4'b0100, 0, 4'b0100, 2, 0);
    add(1, 4'b0100, 1, 4'b0000, 0, 0);
    add(1, 4'b0011, 0, 4'b0001, 0, 0);
    add(1, 4'b0011, 1, 4'b0000, 0, 0);
    add(1, 4'b0011, 0, 4'b0010, 1, 0);
    // master 1 withdraws; next search starts at 2, no preemption by others
    add(1, 4'b0001, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0100, 2, 0);
    add(1, 4'b1111, 0, 4'b0100, 2, 0);
    add(1, 4'b1111, 1, 4'b0000, 0, 0);
    // ack in idle is ignored
    add(1, 4'b0000, 1, 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; req = vecs[i].req; ack = vecs[i].ack;
      step();
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].to);
    end

    // watchdog timeout: master 3 holds grant 8 cycles, then forced release
    ack = 1'b0; req = 4'b1000;
    step();
    check("to_grant", 4'b1000, 3, 0);
    for (int k = 2; k <= 8; k++) begin
      step();
      check($sformatf("to_hold%0d", k), 4'b1000, 3, 0);
    end
    step();
    check("to_fire", 4'b0000, 0, 1);
    step();
    check("to_regrant", 4'b1000, 3, 0);
    // ack on the timeout cycle wins over the watchdog
    for (int k = 2; k <= 8; k++) begin
      step();
      check($sformatf("ack_hold%0d", k), 4'b1000, 3, 0);
    end
    ack = 1'b1;
    step();
    check("ack_at_to", 4'b0000, 0, 0);
    ack = 1'b0; req = 4'b0000;
    step();
    check("ack_at_to_idle", 4'b0000, 0, 0);

    // reset while busy drops grant and restores rr_ptr to 0
    req = 4'b0010;
    step();
    check("rst_pre", 4'b0010, 1, 0);
    rst_n = 1'b0;
    step();
    check("rst_mid", 4'b0000, 0, 0);
    rst_n = 1'b1; req = 4'b1111;
    step();
    check("rst_after", 4'b0001, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
